pc_update: RTL
==============

PC_UPDATE -- requirements
Module: pc_update

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 Parameter PHASES, default 10, the number of clock cycles per instruction frame.
REQ-003 Parameter SAMPLE_PHASE, default 6, the frame phase at which the branch decision is captured.
REQ-004 Parameter UPDATE_PHASE, default 9, the frame phase at which the PC is written.
REQ-005 Port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, asynchronous, active-high reset.
REQ-007 Port saidaAnd, input, 1, branch-taken decision (branch & alu_0) from the branch AND stage.
REQ-008 Port imm, input, 32, sign-extended branch offset in halfwords.
REQ-009 Port stall, input, 1, suppresses the PC write in the current frame.
REQ-010 Port pc, output, 32, current program counter.
REQ-011 Port pc_plus4, output, 32, combinational pc + 4, modulo 2^32.
REQ-012 Port phase, output, 4, current frame phase, 0..PHASES-1.
REQ-013 Port pc_valid, output, 1, one-cycle pulse on the cycle after each successful PC write.
REQ-014 Port misalign_err, output, 1, sticky flag for a rejected, non-word-aligned branch target.

Function
REQ-015 The phase counter increments every cycle, wraps from PHASES-1 to 0, and is never affected by stall.
REQ-016 The phase counter stays in lockstep with the branch AND stage, since both reset to 0 on the same reset.
REQ-017 At phase == SAMPLE_PHASE: taken_q <= saidaAnd and target_q <= pc + {imm[30:0],1'b0}, with the addition modulo 2^32.
REQ-018 At phase == UPDATE_PHASE with stall=0, taken_q=0: pc <= pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-019 At phase == UPDATE_PHASE with stall=0, taken_q=1, target_q[1:0]==2'b00: pc <= target_q.
REQ-020 At phase == UPDATE_PHASE with stall=0, taken_q=1, target_q[1:0]!=2'b00: pc is held and misalign_err <= 1.
REQ-021 At phase == UPDATE_PHASE with stall=1: pc, taken_q and target_q are held, and pc_valid does not pulse.
REQ-022 Values held by a stall are overwritten at the next SAMPLE_PHASE.
REQ-023 pc_valid is 1 in the cycle following a successful write (REQ-018 or REQ-019) and is 0 otherwise.
REQ-024 saidaAnd, imm and stall are ignored outside SAMPLE_PHASE and UPDATE_PHASE respectively.
REQ-025 misalign_err stays 1 until reset.
REQ-026 pc[1:0] is 2'b00 at all times after reset, given that RESET_PC is word-aligned.

Reset
REQ-027 On reset, outputs and state take these values: pc=RESET_PC, phase=0, taken_q=0, target_q=0, pc_valid=0, misalign_err=0.
REQ-028 Reset asserted mid-frame aborts the frame with no PC write, and the first frame after release starts at phase 0.
REQ-029 Reset release is synchronous to clock, so phase 0 is the first cycle after deassertion.

Structure
REQ-030 A shared package holds PHASES, SAMPLE_PHASE, UPDATE_PHASE, XLEN=32 and the RESET_PC default, shared with the branch AND stage.
REQ-031 The phase counter is a sub-module, phase_counter, reused by every frame-sequenced stage.
REQ-032 The PC datapath (adders, select, alignment check) stays inline in pc_update.

Verification
REQ-033 Reset, then 3 frames with saidaAnd=0, stall=0 -> pc = 0x0, 0x4, 0x8, 0xC, with a pc_valid pulse at each phase 0 after the write.
REQ-034 pc=0x100, imm=0x10, saidaAnd=1 at phase 6 -> pc=0x120 after phase 9.
REQ-035 pc=0x100, imm=0xFFFF_FFF8 (-8), saidaAnd=1 -> pc=0xF0.
REQ-036 saidaAnd=1 at phase 5 only, 0 at phase 6 -> pc=pc+4, confirming the sample is taken only at SAMPLE_PHASE.
REQ-037 stall=1 at phase 9 -> pc unchanged and no pc_valid pulse; next frame with stall=0 -> normal advance.
REQ-038 Combined boundary cases:
- imm=0x1 with saidaAnd=1 -> pc held and misalign_err=1.
- pc=0xFFFF_FFFC, not taken -> pc=0x0.
- reset pulse at phase 7 -> pc=RESET_PC and phase=0.

Source files
------------

// File: rtl/pc_update_pkg.sv
// Shared frame-timing constants and PC select encoding for the frame-sequenced
// pipeline stages (pc_update, branch AND stage).
package pc_update_pkg;

    localparam int unsigned XLEN                 = 32;
    localparam int unsigned PHASE_W              = 4;
    localparam int unsigned PHASES_DEFAULT       = 10;
    localparam int unsigned SAMPLE_PHASE_DEFAULT = 6;
    localparam int unsigned UPDATE_PHASE_DEFAULT = 9;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ      = 2'd0,
        PC_BRANCH   = 2'd1,
        PC_MISALIGN = 2'd2
    } pc_sel_e;

    function automatic logic word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_update_phase_counter.sv
// Free-running frame phase counter, 0..PHASES-1; shared by every frame-sequenced
// stage so all of them stay in lockstep after a common reset.
module phase_counter
    import pc_update_pkg::*;
#(
    parameter int unsigned PHASES = PHASES_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    output logic [PHASE_W-1:0] phase
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (phase == PHASE_W'(PHASES - 1)) begin
            phase <= '0;
        end else begin
            phase <= phase + PHASE_W'(1);
        end
    end

endmodule

// File: rtl/pc_update.sv
// Program counter update stage: captures the branch decision at SAMPLE_PHASE
// and writes the PC (sequential, branch, or rejected misaligned) at UPDATE_PHASE.
module pc_update
    import pc_update_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int unsigned     PHASES       = PHASES_DEFAULT,
    parameter int unsigned     SAMPLE_PHASE = SAMPLE_PHASE_DEFAULT,
    parameter int unsigned     UPDATE_PHASE = UPDATE_PHASE_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               saidaAnd,
    input  logic [XLEN-1:0]    imm,
    input  logic               stall,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus4,
    output logic [PHASE_W-1:0] phase,
    output logic               pc_valid,
    output logic               misalign_err
);

    logic            taken_q;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] branch_target;
    logic            sample_now;
    logic            update_now;
    pc_sel_e         pc_sel;

    phase_counter #(
        .PHASES(PHASES)
    ) u_phase_counter (
        .clock(clock),
        .reset(reset),
        .phase(phase)
    );

    // imm is a halfword offset; shifting drops imm[31], matching {imm[30:0],1'b0}
    always_comb begin
        pc_plus4      = pc + XLEN'(4);
        branch_target = pc + (imm << 1);
        sample_now    = (phase == PHASE_W'(SAMPLE_PHASE));
        update_now    = (phase == PHASE_W'(UPDATE_PHASE)) && !stall;
        pc_sel        = PC_SEQ;
        if (taken_q) begin
            pc_sel = word_aligned(target_q) ? PC_BRANCH : PC_MISALIGN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            taken_q      <= 1'b0;
            target_q     <= '0;
            pc_valid     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            pc_valid <= 1'b0;
            if (sample_now) begin
                taken_q  <= saidaAnd;
                target_q <= branch_target;
            end
            if (update_now) begin
                unique case (pc_sel)
                    PC_SEQ: begin
                        pc       <= pc_plus4;
                        pc_valid <= 1'b1;
                    end
                    PC_BRANCH: begin
                        pc       <= target_q;
                        pc_valid <= 1'b1;
                    end
                    PC_MISALIGN: begin
                        misalign_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
